// File: rtl/multiword_add_seq.sv
// Streams WORDS x 16-bit add/sub LSB-first through an external combinational 16-bit adder.
// Latency: done in the cycle after edge WORDS; start is taken only when ready=1 and ignored while busy.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic                cin,
  input  logic [16*WORDS-1:0] a_in,
  input  logic [16*WORDS-1:0] b_in,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_c,
  input  logic [15:0]         add_sum,
  input  logic                add_cout,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] result,
  output logic                cout,
  output logic                ovf
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            accept;
  logic            last;
  logic [15:0]     a_sl, b_sl;

  assign last  = (idx == IW'(WORDS - 1));
  assign ready = (state != RUN);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (last) state_nxt = DONE;
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slice select uses constant indices so every part-select is static.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[16*i +: 16];
        b_sl = b_q[16*i +: 16];
      end
    end
  end

  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = 1'b0;
    if (state == RUN) begin
      add_a = a_sl;
      add_b = sub_q ? ~b_sl : b_sl;
      add_c = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        sub_q <= op_sub;
        idx   <= '0;
        carry <= op_sub ? 1'b1 : cin;
      end else if (state == RUN) begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx == IW'(i)) result[16*i +: 16] <= add_sum;
        end
        carry <= add_cout;
        idx   <= idx + IW'(1);
        if (last) begin
          cout <= add_cout;
          ovf  <= (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
        end
      end
    end
  end

endmodule
